grid_snapshot_ctrl: RTL and testbench

Avalon-MM slave controller that sequences CPU readout of the 10x20 Tetris playfield. On CPU request it waits for the game logic to report a stable grid, captures all 200 bits into a snapshot register in one cycle, then serves rows from that snapshot by direct address or by an auto-incrementing stream pointer. The CPU therefore never sees a grid torn mid-update. Sits between the game-logic grid register and the Nios II data bus.

---
 rtl/grid_snapshot_ctrl_if.sv | 24 ++
 rtl/grid_snapshot_ctrl.sv | 142 ++++++++++++++
 tb/tb_grid_snapshot_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/grid_snapshot_ctrl_if.sv
// rtl/grid_snapshot_ctrl_if.sv - Avalon-MM slave bus bundle for the grid snapshot controller
interface grid_snapshot_ctrl_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/grid_snapshot_ctrl.sv
// rtl/grid_snapshot_ctrl.sv - tear-free CPU snapshot of the 10x20 playfield, row/stream readout
// Optional wait timeout with stale flag: define GRID_TIMEOUT_EN.
module grid_snapshot_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [199:0]         grid_state,
  input  logic                 grid_stable,
  grid_snapshot_ctrl_if.slave  avs
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_READY   = 2'd3
  } state_e;

  localparam logic [4:0] ADDR_CTRL   = 5'd20;
  localparam logic [4:0] ADDR_COUNT  = 5'd21;
  localparam logic [4:0] ADDR_STREAM = 5'd22;
  localparam logic [4:0] LAST_ROW    = 5'd19;

  state_e         state_q;
  logic [199:0]   snap_q;
  logic [4:0]     ptr_q;
  logic [4:0]     ptr_d;
  logic [15:0]    count_q;
  logic           valid_q;
  logic           busy_q;
  logic           stale;
  logic [31:0]    rdata_q;
  logic [31:0]    rdata_d;
  logic [9:0]     addr_row;
  logic [9:0]     ptr_row;
  logic           request;
  logic           stream_rd;
  logic           unused_wdata;

`ifdef GRID_TIMEOUT_EN
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wait_cnt_q;
  logic        timed_out_q;
  logic        stale_q;
  assign stale = stale_q;
`else
  assign stale = 1'b0;
`endif

  assign unused_wdata = &{1'b0, avs.avs_writedata[31:1]};
  assign request   = avs.avs_write && (avs.avs_address == ADDR_CTRL) && avs.avs_writedata[0];
  assign stream_rd = avs.avs_read && (avs.avs_address == ADDR_STREAM);
  assign ptr_d     = (ptr_q == LAST_ROW) ? 5'd0 : ptr_q + 5'd1;
  assign avs.avs_readdata = rdata_q;

  always_comb begin
    addr_row = '0;
    ptr_row  = '0;
    for (int r = 0; r < 20; r++) begin
      if (avs.avs_address == 5'(r)) addr_row = snap_q[10*r +: 10];
      if (ptr_q == 5'(r))           ptr_row  = snap_q[10*r +: 10];
    end
  end

  // Reads see register state from before this edge, so a read coinciding
  // with a capture returns the previous snapshot.
  always_comb begin
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      if (avs.avs_address <= LAST_ROW) begin
        rdata_d = {22'd0, addr_row};
      end else begin
        case (avs.avs_address)
          ADDR_CTRL:   rdata_d = {29'd0, stale, busy_q, valid_q};
          ADDR_COUNT:  rdata_d = {16'd0, count_q};
          ADDR_STREAM: rdata_d = {22'd0, ptr_row};
          default:     rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      snap_q      <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
`ifdef GRID_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timed_out_q <= 1'b0;
      stale_q     <= 1'b0;
`endif
    end else begin
      rdata_q <= rdata_d;
      if (stream_rd) ptr_q <= ptr_d;

      case (state_q)
        S_EMPTY, S_READY: begin
          if (request) begin
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
`ifdef GRID_TIMEOUT_EN
            wait_cnt_q  <= '0;
            timed_out_q <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (grid_stable) begin
            state_q <= S_CAPTURE;
`ifdef GRID_TIMEOUT_EN
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q     <= S_CAPTURE;
            timed_out_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
`endif
          end
        end
        S_CAPTURE: begin
          // Capture overrides any stream increment issued on this edge.
          snap_q  <= grid_state;
          ptr_q   <= '0;
          count_q <= count_q + 16'd1;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_READY;
`ifdef GRID_TIMEOUT_EN
          stale_q <= timed_out_q;
`endif
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_snapshot_ctrl.sv
// tb/tb_grid_snapshot_ctrl.sv - directed and randomized checks of grid_snapshot_ctrl against a behavioural model
module tb_grid_snapshot_ctrl;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [199:0] grid;
  logic         stable;
  int           tests = 0;
  int           fails = 0;

  grid_snapshot_ctrl_if bus ();

  grid_snapshot_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .grid_state  (grid),
    .grid_stable (stable),
    .avs         (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: snapshot image, pointer, counter and a pending-capture notion.
  logic [199:0] m_snap;
  int           m_ptr, m_count, m_waited, nptr;
  bit           m_valid, m_stale, m_wait, m_cap, m_timed, m_busy, started;
  logic [31:0]  m_rd;

  always @(posedge clk) begin
    started = 1'b1;
    if (!reset_n) begin
      m_snap = '0; m_ptr = 0; m_count = 0; m_waited = 0;
      m_valid = 0; m_stale = 0; m_wait = 0; m_cap = 0; m_timed = 0;
      m_rd = '0;
    end else begin
      m_busy = m_wait || m_cap;
      nptr = m_ptr;
      if (bus.avs_read) begin
        if (bus.avs_address < 20)       m_rd = {22'd0, m_snap[10*int'(bus.avs_address) +: 10]};
        else if (bus.avs_address == 20) m_rd = {29'd0, m_stale, m_busy, m_valid};
        else if (bus.avs_address == 21) m_rd = m_count;
        else if (bus.avs_address == 22) begin
          m_rd = {22'd0, m_snap[10*m_ptr +: 10]};
          nptr = (m_ptr + 1) % 20;
        end else m_rd = '0;
      end
      if (m_cap) begin
        m_snap = grid; nptr = 0; m_count = (m_count + 1) % 65536;
        m_valid = 1; m_stale = m_timed; m_cap = 0;
      end else if (m_wait) begin
        if (stable) begin
          m_wait = 0; m_cap = 1; m_timed = 0;
        end else begin
`ifdef GRID_TIMEOUT_EN
          if (m_waited + 1 >= TMO) begin
            m_wait = 0; m_cap = 1; m_timed = 1;
          end else m_waited++;
`endif
        end
      end else if (bus.avs_write && bus.avs_address == 20 && bus.avs_writedata[0]) begin
        m_wait = 1; m_waited = 0;
      end
      m_ptr = nptr;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      tests++;
      if (bus.avs_readdata !== m_rd) begin
        fails++;
        $display("FAIL model_rd t=%0t: got 0x%08h expected 0x%08h", $time, bus.avs_readdata, m_rd);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_lit(input logic [4:0] a, input logic [31:0] exp, input string nm);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    tests++;
    if (bus.avs_readdata !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, bus.avs_readdata, exp);
    end
  endtask

  task automatic wr_req();
    bus.avs_address = 5'd20; bus.avs_writedata = 32'd1; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0; bus.avs_writedata = '0;
  endtask

  function automatic logic [199:0] ramp_grid();
    logic [199:0] g;
    for (int r = 0; r < 20; r++) g[10*r +: 10] = 10'(r * 37 + 5);
    return g;
  endfunction

  logic [199:0] g2;
  int           slow_mode;

  initial begin
    reset_n = 1'b0; grid = '0; stable = 1'b0;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    idle(3);
    reset_n = 1'b1;

    rd_lit(5'd0,  32'h0, "rst_row0");
    rd_lit(5'd20, 32'h0, "rst_status");
    rd_lit(5'd21, 32'h0, "rst_count");
    rd_lit(5'd22, 32'h0, "rst_stream");

    grid = '0; grid[199:190] = 10'h3FF; grid[9:0] = 10'h001; stable = 1'b1;
    wr_req();
    idle(2);
    rd_lit(5'd20, 32'h1,   "cap_status");
    rd_lit(5'd19, 32'h3FF, "cap_row19");
    rd_lit(5'd0,  32'h1,   "cap_row0");
    rd_lit(5'd21, 32'h1,   "cap_count");

    g2 = ramp_grid();
`ifndef GRID_TIMEOUT_EN
    stable = 1'b0;
    wr_req();
    grid = g2;
    for (int i = 0; i < 5; i++) begin
      rd_lit(5'd20, 32'h3,   "wait_status");
      rd_lit(5'd19, 32'h3FF, "wait_old_row19");
      if (i == 2) wr_req();
      idle(7);
    end
    stable = 1'b1;
    idle(2);
    rd_lit(5'd20, 32'h1, "stall_status");
    rd_lit(5'd21, 32'h2, "stall_count");
`else
    stable = 1'b0;
    wr_req();
    grid = g2;
    idle(TMO + 3);
    rd_lit(5'd20, 32'h5, "tmo_status");
    rd_lit(5'd21, 32'h2, "tmo_count");
    stable = 1'b1;
    wr_req();
    idle(2);
    rd_lit(5'd20, 32'h1, "tmo_clear_status");
`endif

    for (int i = 0; i < 21; i++)
      rd_lit(5'd22, {22'd0, g2[10*(i % 20) +: 10]}, "stream");
    for (int i = 0; i < 4; i++) rd_lit(5'd22, {22'd0, g2[10*(i + 1) +: 10]}, "stream_pre");
    wr_req();
    idle(2);
    rd_lit(5'd22, {22'd0, g2[9:0]}, "stream_restart");

    stable = 1'b0;
    wr_req();
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    stable = 1'b1;
    rd_lit(5'd20, 32'h0, "rstwait_status");
    rd_lit(5'd21, 32'h0, "rstwait_count");
    rd_lit(5'd19, 32'h0, "rstwait_row19");
    rd_lit(5'd22, 32'h0, "rstwait_stream");

    slow_mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) slow_mode = $urandom_range(0, 2);
      bus.avs_read      = ($urandom % 2) == 1;
      bus.avs_write     = ($urandom % 4) == 0;
      bus.avs_address   = (($urandom % 3) == 0) ? 5'd20 : 5'($urandom % 32);
      if (($urandom % 4) == 0) bus.avs_address = 5'd22;
      bus.avs_writedata = $urandom;
      stable  = (slow_mode == 0) ? (($urandom % 4) != 0) : (($urandom % 40) == 0);
      reset_n = ($urandom % 600) != 0;
      if (($urandom % 3) == 0)
        for (int b = 0; b < 200; b++) grid[b] = 1'($urandom % 2);
      @(negedge clk);
    end
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; reset_n = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
